// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan controller: address packing,
// bit-plane range and the shift FSM states.
package hub75_pkg;
  localparam int COL_BITS  = 9;
  localparam int ROW_BITS  = 5;
  localparam int PLANE_MSB = 7;
  localparam int PLANE_LSB = 2;

  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_BLANK, ST_LATCH} scan_state_t;

  typedef struct packed {
    logic r0, g0, b0, r1, g1, b1;
  } rgb_pair_t;

  function automatic logic [ROW_BITS+COL_BITS-1:0] pack_addr(
    input logic [ROW_BITS-1:0] row, input logic [COL_BITS-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/hub75_oe_timer.sv
// Display-time down-counter: drives the panel output enable for the weight of
// the latched plane, and flags done in the last enabled cycle so the next
// blanking window starts right after it.
module hub75_oe_timer import hub75_pkg::*; #(
  parameter int BASE_OE = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [2:0] plane,
  output logic       oe_n,
  output logic       done
);
  localparam int TW = $clog2(BASE_OE*32+1);

  logic [TW-1:0] cnt;
  logic [TW-1:0] weight;

  assign weight = TW'(BASE_OE) << (plane - 3'(PLANE_LSB));

  // cnt holds the remaining enabled cycles minus one, so done rises with cnt==0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      oe_n <= 1'b1;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= weight - TW'(1);
      oe_n <= 1'b0;
      done <= (weight == TW'(1));
    end else if (!oe_n) begin
      if (cnt == '0) begin
        oe_n <= 1'b1;
      end else begin
        cnt  <= cnt - TW'(1);
        done <= (cnt == TW'(1));
      end
    end
  end
endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: walks rows 0..31 and planes 7..2, shifting the next
// plane while the current one is displayed (binary-coded modulation).
module hub75_scan_ctrl import hub75_pkg::*; #(
  parameter int PANELS    = 2,
  parameter int BASE_OE   = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic [13:0] rd_addr,
  output logic [2:0]  rd_bit_plane,
  input  logic        r0, g0, b0, r1, g1, b1,
  output logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
  output logic        hub_clk,
  output logic        hub_lat,
  output logic        hub_oe_n,
  output logic [4:0]  hub_row,
  output logic        frame_done
);
  localparam int COLS = 64*PANELS;
  localparam int SC_W = $clog2(2*COLS+2);
  localparam int BC_W = $clog2(BLANK_CYC+1);
  localparam logic [SC_W-1:0] T_DLAST = SC_W'(2*COLS-1);
  localparam logic [SC_W-1:0] T_CLAST = SC_W'(2*COLS);
  localparam logic [SC_W-1:0] T_END   = SC_W'(2*COLS+1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLANK_CYC-1);

  if (PANELS < 1 || PANELS > 8) begin : g_bad_panels
    $error("hub75_scan_ctrl: PANELS must be in 1..8");
  end
  if (BASE_OE < 1) begin : g_bad_oe
    $error("hub75_scan_ctrl: BASE_OE must be >= 1");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("hub75_scan_ctrl: BLANK_CYC must be >= 1");
  end

  scan_state_t          state;
  logic [SC_W-1:0]      t;
  logic [BC_W-1:0]      bc;
  logic [ROW_BITS-1:0]  row, row_nxt;
  logic                 stop_pend, last, tmr_done;
  rgb_pair_t            mem_d, hub_d;

  assign mem_d   = {r0, g0, b0, r1, g1, b1};
  assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = hub_d;
  assign last    = (row == ROW_BITS'(31)) && (rd_bit_plane == 3'(PLANE_LSB));
  assign row_nxt = (rd_bit_plane == 3'(PLANE_LSB)) ? row + ROW_BITS'(1) : row;

  hub75_oe_timer #(.BASE_OE(BASE_OE)) u_oe_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (state == ST_LATCH),
    .plane  (rd_bit_plane),
    .oe_n   (hub_oe_n),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      t            <= '0;
      bc           <= '0;
      row          <= '0;
      stop_pend    <= 1'b0;
      rd_addr      <= '0;
      rd_bit_plane <= 3'(PLANE_MSB);
      hub_d        <= '0;
      hub_clk      <= 1'b0;
      hub_lat      <= 1'b0;
      hub_row      <= '0;
      frame_done   <= 1'b0;
    end else begin
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (enable) begin
          state        <= ST_SHIFT;
          t            <= '0;
          row          <= '0;
          rd_bit_plane <= 3'(PLANE_MSB);
          rd_addr      <= pack_addr('0, '0);
        end
        ST_SHIFT: begin
          // two cycles per column: address, then capture; clock rises a cycle later
          if (t[0] && t <= T_DLAST) hub_d <= mem_d;
          if (t[0] && t < T_DLAST)
            rd_addr <= pack_addr(row, rd_addr[COL_BITS-1:0] + COL_BITS'(1));
          hub_clk <= !t[0] && (t >= SC_W'(2)) && (t <= T_CLAST);
          if (t == T_END) state <= ST_WAIT;
          t <= t + SC_W'(1);
        end
        ST_WAIT: if (tmr_done) begin
          if (stop_pend) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
          end else begin
            state <= ST_BLANK;
            bc    <= '0;
          end
        end
        ST_BLANK: begin
          if (bc == BC_LAST) begin
            state   <= ST_LATCH;
            hub_lat <= 1'b1;
            hub_row <= row;
          end else begin
            bc <= bc + BC_W'(1);
          end
        end
        ST_LATCH: begin
          frame_done   <= last;
          row          <= row_nxt;
          rd_bit_plane <= (rd_bit_plane == 3'(PLANE_LSB)) ? 3'(PLANE_MSB)
                                                           : rd_bit_plane - 3'(1);
          // enable only matters at frame boundaries; a stop drains the last display
          if (last && !enable) begin
            state     <= ST_WAIT;
            stop_pend <= 1'b1;
          end else begin
            state   <= ST_SHIFT;
            t       <= '0;
            rd_addr <= pack_addr(row_nxt, '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with PANELS=1, BASE_OE=4, BLANK_CYC=2.
module tb_hub75_scan_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] rd_addr;
  logic [2:0]  rd_bit_plane;
  logic        r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
  logic        hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [4:0]  hub_row;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_lat = 0;
  int lat_idx = 0;

  hub75_scan_ctrl #(.PANELS(1), .BASE_OE(4), .BLANK_CYC(2)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .rd_addr(rd_addr), .rd_bit_plane(rd_bit_plane),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_row(hub_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: one-cycle read latency, data bits derived from the column
  always @(posedge clk) begin
    r0 <= rd_addr[0]; g1 <= rd_addr[1]; g0 <= rd_addr[2];
    b0 <= rd_addr[3]; r1 <= rd_addr[4]; b1 <= rd_addr[5];
  end

  function automatic logic [31:0] out_vec();
    return {rd_addr, rd_bit_plane, hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
            hub_clk, hub_lat, hub_oe_n, hub_row, frame_done};
  endfunction

  localparam logic [31:0] RST_VEC = {14'd0, 3'd7, 6'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0};

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
    end
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({hub_clk, hub_lat, hub_oe_n} !== 3'b001) begin
      errors++; $display("FAIL idle_quiet: got clk/lat/oe_n=%b want 001", {hub_clk, hub_lat, hub_oe_n});
    end
  endtask

  task automatic test_first_plane();
    int c0, d, nclk, first_clk, lat_c, run;
    logic [13:0] ea;
    logic [5:0]  k, got;
    nclk = 0; first_clk = -1; lat_c = -1; run = 0;
    enable = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      d = cyc - c0;
      if (d >= 1 && d <= 130) begin
        ea = (d - 1) / 2 > 63 ? 14'd63 : 14'((d - 1) / 2);
        checks++;
        if (rd_addr !== ea) begin
          errors++; $display("FAIL rd_addr t=%0d: got %0d want %0d", d - 1, rd_addr, ea);
        end
      end
      if (hub_clk === 1'b1 && lat_c < 0) begin
        if (first_clk < 0) first_clk = d;
        k = 6'(nclk);
        got = {hub_b1, hub_r1, hub_b0, hub_g0, hub_g1, hub_r0};
        checks++;
        if (got !== k) begin
          errors++; $display("FAIL col_data k=%0d: got %b want %b", nclk, got, k);
        end
        nclk++;
      end
      if (hub_lat === 1'b1 && lat_c < 0) begin
        lat_c = d;
        checks++;
        if (hub_row !== 5'd0 || rd_bit_plane !== 3'd7) begin
          errors++; $display("FAIL first_latch: got row %0d plane %0d want 0 7", hub_row, rd_bit_plane);
        end
      end
      if (lat_c >= 0 && hub_oe_n === 1'b0) run++;
      else if (run > 0) break;
    end
    checks++;
    if (first_clk !== 4) begin
      errors++; $display("FAIL clk_latency: got %0d want 4", first_clk);
    end
    checks++;
    if (nclk !== 64) begin
      errors++; $display("FAIL clk_pulses: got %0d want 64", nclk);
    end
    checks++;
    if (lat_c !== 134) begin
      errors++; $display("FAIL latch_time: got %0d want 134", lat_c);
    end
    checks++;
    if (run !== 128) begin
      errors++; $display("FAIL oe_width_p7: got %0d want 128", run);
    end
    last_lat = c0 + lat_c;
    lat_idx = 1;
  endtask

  task automatic test_full_row();
    int nl, run, wi;
    int exp_w[5] = '{64, 32, 16, 8, 4};
    logic [2:0] ep;
    logic [4:0] er;
    nl = 0; run = 0; wi = 0;
    for (int n = 0; n < 2000 && nl < 6; n++) begin
      @(negedge clk);
      if (hub_oe_n === 1'b0) run++;
      else if (run > 0) begin
        checks++;
        if (wi > 4 || run !== exp_w[wi > 4 ? 4 : wi]) begin
          errors++; $display("FAIL oe_width idx=%0d: got %0d want %0d", wi, run, exp_w[wi > 4 ? 4 : wi]);
        end
        wi++; run = 0;
      end
      if (hub_lat === 1'b1) begin
        nl++;
        ep = nl < 6 ? 3'(7 - nl) : 3'd7;
        er = nl < 6 ? 5'd0 : 5'd1;
        checks++;
        if (cyc - last_lat !== 134) begin
          errors++; $display("FAIL latch_period n=%0d: got %0d want 134", nl, cyc - last_lat);
        end
        checks++;
        if (rd_bit_plane !== ep || hub_row !== er) begin
          errors++; $display("FAIL row_latch n=%0d: got row %0d plane %0d want %0d %0d", nl, hub_row, rd_bit_plane, er, ep);
        end
        last_lat = cyc;
      end
    end
    checks++;
    if (nl !== 6 || wi !== 5) begin
      errors++; $display("FAIL row_complete: got latches %0d widths %0d want 6 5", nl, wi);
    end
    lat_idx = 7;
  endtask

  task automatic test_full_frame();
    int nfd, fin_c, maxrow;
    bit done;
    logic [2:0] ep;
    logic [4:0] er;
    nfd = 0; fin_c = -10; maxrow = 0; done = 0;
    for (int n = 0; n < 30000 && !done; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        nfd++;
        checks++;
        if (cyc !== fin_c + 1) begin
          errors++; $display("FAIL frame_done_time: got %0d want %0d", cyc, fin_c + 1);
        end
      end
      if (hub_lat === 1'b1) begin
        er = 5'((lat_idx / 6) % 32);
        ep = 3'(7 - lat_idx % 6);
        checks++;
        if (hub_row !== er || rd_bit_plane !== ep) begin
          errors++; $display("FAIL frame_seq idx=%0d: got row %0d plane %0d want %0d %0d", lat_idx, hub_row, rd_bit_plane, er, ep);
        end
        if (int'(hub_row) > maxrow) maxrow = int'(hub_row);
        if (lat_idx == 191) fin_c = cyc;
        if (lat_idx == 192) done = 1;
        lat_idx++;
      end
    end
    checks++;
    if (!done || nfd !== 1 || maxrow !== 31) begin
      errors++; $display("FAIL frame_end: got done %0d pulses %0d maxrow %0d want 1 1 31", done, nfd, maxrow);
    end
  endtask

  task automatic test_stop();
    int fin_c, nfd, nclk, nlat, nfd2;
    logic [2:0] ep;
    logic [4:0] er;
    fin_c = -10; nfd = 0; nclk = 0; nlat = 0; nfd2 = 0;
    for (int n = 0; n < 30000 && nfd == 0; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        nfd++;
        checks++;
        if (cyc !== fin_c + 1) begin
          errors++; $display("FAIL stop_done_time: got %0d want %0d", cyc, fin_c + 1);
        end
      end
      if (hub_lat === 1'b1) begin
        er = 5'((lat_idx / 6) % 32);
        ep = 3'(7 - lat_idx % 6);
        checks++;
        if (hub_row !== er || rd_bit_plane !== ep) begin
          errors++; $display("FAIL stop_seq idx=%0d: got row %0d plane %0d want %0d %0d", lat_idx, hub_row, rd_bit_plane, er, ep);
        end
        if (hub_row === 5'd10) enable = 1'b0;
        if (hub_row === 5'd31 && rd_bit_plane === 3'd2) fin_c = cyc;
        lat_idx++;
      end
    end
    checks++;
    if (nfd !== 1) begin
      errors++; $display("FAIL stop_frame_done: got %0d want 1", nfd);
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (hub_clk === 1'b1) nclk++;
      if (hub_lat === 1'b1) nlat++;
      if (frame_done === 1'b1) nfd2++;
    end
    checks++;
    if (nclk !== 0 || nlat !== 0 || nfd2 !== 0) begin
      errors++; $display("FAIL stop_quiet: got clk %0d lat %0d fd %0d want 0 0 0", nclk, nlat, nfd2);
    end
    checks++;
    if (hub_oe_n !== 1'b1) begin
      errors++; $display("FAIL stop_oe: got %b want 1", hub_oe_n);
    end
  endtask

  task automatic test_mid_reset();
    int c0, lat_c;
    bit seen;
    seen = 0; lat_c = -1;
    enable = 1'b1;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      if (hub_oe_n === 1'b0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL display_start: got no oe_n low want oe_n low");
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL mid_reset_now: got %h want %h", out_vec(), RST_VEC);
    end
    @(negedge clk);
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL mid_reset_hold: got %h want %h", out_vec(), RST_VEC);
    end
    resetn = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 400 && lat_c < 0; n++) begin
      @(negedge clk);
      if (hub_lat === 1'b1) begin
        lat_c = cyc - c0;
        checks++;
        if (hub_row !== 5'd0 || rd_bit_plane !== 3'd7) begin
          errors++; $display("FAIL restart_latch: got row %0d plane %0d want 0 7", hub_row, rd_bit_plane);
        end
      end
    end
    checks++;
    if (lat_c !== 134) begin
      errors++; $display("FAIL restart_time: got %0d want 134", lat_c);
    end
  endtask

  initial begin
    test_reset();
    test_first_plane();
    test_full_row();
    test_full_frame();
    test_stop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Display-side scan controller for the HUB75 LED matrix cape. It walks the frame buffer memory block's read port row by row and bit plane by bit plane, and shifts the RGB bits for the upper and lower row pair out to the panel chain. It also generates the panel shift clock, latch, output-enable and row-select signals. Brightness uses binary-coded modulation over bit planes 7..2, and shifting of the next plane overlaps display of the current one.

## Interface
- PANELS, 2, panels chained horizontally; legal range 1..8, else elaboration error; COLS = 64*PANELS
- BASE_OE, 4, display cycles for plane 2 (LSB); plane p displays BASE_OE<<(p-2) cycles; minimum 1
- BLANK_CYC, 2, cycles oe_n held high before each latch; minimum 1

- clk  in  1  system clock; only clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  run request; sampled only at frame start
- rd_addr  out  14  memory read address {row[4:0], col[8:0]}
- rd_bit_plane  out  3  plane selected at the memory output mux
- r0, g0, b0, r1, g1, b1  in  1 each  memory outputs for rows n and n+32; valid 1 cycle after rd_addr
- hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1  out  1 each  registered panel data
- hub_clk  out  1  panel shift clock
- hub_lat  out  1  panel latch strobe, active high
- hub_oe_n  out  1  panel output enable, active low
- hub_row  out  5  row select A..E
- frame_done  out  1  one-cycle pulse after row 31, plane 2 is latched

## Operation
- Order: rows 0→31; within each row, planes 7→2. The plane 2 data for red and blue arrives as 0 from memory and is shifted as-is.
- Shift FSM states: IDLE, SHIFT, WAIT, BLANK, LATCH.
- IDLE: hub_oe_n=1. When enable=1, go to SHIFT at row 0, plane 7.
- SHIFT: issue COLS addresses and produce COLS hub_clk pulses, then go to WAIT.
- WAIT: hold until the display timer reports done. If the timer is already done, stay 1 cycle.
- BLANK: hub_oe_n=1 for BLANK_CYC cycles.
- LATCH: hub_lat=1 for 1 cycle. In the same cycle, hub_row takes the shifted row and the display timer loads BASE_OE<<(plane-2).
  - The next cycle has hub_oe_n=0.
  - The FSM advances plane/row and enters SHIFT immediately.
- Display timer: counts down while hub_oe_n=0 and sets done at 0. The counter is wide enough for BASE_OE*32.
- After LATCH of row 31, plane 2:
  - frame_done pulses.
  - If enable=1, continue at row 0, plane 7.
  - Otherwise go to IDLE once the timer is done; hub_oe_n returns to 1.
- enable deasserted mid-frame: the frame completes normally.
- Reset mid-operation: all outputs go immediately to reset values and the FSM goes to IDLE.

## Timing
- Reset values:
  - rd_addr=0, rd_bit_plane=3'd7
  - hub data=0, hub_clk=0, hub_lat=0, hub_oe_n=1, hub_row=0
  - frame_done=0; timer done=1
- SHIFT cycle t=0 is state entry. For column k:
  - rd_addr={row,k} in cycles 2k and 2k+1.
  - Memory data is sampled into hub data at the end of cycle 2k+1, so hub data is stable in cycles 2k+2 and 2k+3.
  - hub_clk=1 in cycle 2k+3 only.
- SHIFT length is 2*COLS+2 cycles. hub_lat never coincides with hub_clk=1.
- rd_bit_plane changes only outside SHIFT.
- Plane period = max(2*COLS+2+1, weight) + BLANK_CYC + 1 cycles. The +1 is the minimum 1-cycle WAIT.
- Latency from enable=1 in IDLE to the first hub_clk: 4 cycles.

## Structure
- Shared package hub75_pkg holds:
  - COL_BITS=9, ROW_BITS=5
  - PLANE_MSB=7, PLANE_LSB=2
  - the FSM state enum
  - the {row, col} address-packing function
- Sub-module hub75_oe_timer contains the loadable down-counter, the oe_n drive and the done flag. The FSM, the column/row/plane counters and the data registers stay in hub75_scan_ctrl.

## Test plan
- Reset: assert resetn=0 during display → all outputs take reset values in the same cycle, including hub_oe_n=1. After release with enable=1, hub_row=0 and rd_bit_plane=7 on the first LATCH.
- PANELS=1, BASE_OE=4, first plane → exactly 64 hub_clk pulses, rd_addr 0..63, one hub_lat with hub_row=0, then hub_oe_n low for exactly 128 cycles.
- Memory model returning r0=col[0], g1=col[1] → at each hub_clk rise for column k, hub_r0=k[0] and hub_g1=k[1]; all 64 columns match.
- Full row, BASE_OE=4 → display widths 128, 64, 32, 16, 8, 4 for planes 7..2. For planes ≤6, each latch is 131+BLANK_CYC+1 cycles after the previous one, since shift-bound. hub_row steps 0→1 after plane 2.
- Full frame → hub_row reaches 31; frame_done pulses once, in the cycle after the row 31, plane 2 latch; the next latch shows hub_row=0, plane 7.
- Drop enable at row 10 → frame completes through row 31, frame_done pulses, then hub_oe_n=1 and no further hub_clk.
